// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: redirect/halt handling, post-redirect bubble, sticky halt.
// Optional FETCH_STATS_EN adds saturating RedirectCount / StallCount outputs.
module fetch_pc_unit #(
    parameter int unsigned      PC_W     = 9,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int unsigned      BUBBLES  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Halt,
    input  logic            Stall,
    output logic [PC_W-1:0] PC,
    output logic            IfValid,
    output logic            Flush,
    output logic            Halted,
    output logic            Misaligned
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]     RedirectCount,
    output logic [15:0]     StallCount
`endif
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [3:0] BUBBLE_LOAD = 4'(BUBBLES - 1);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            if_valid_q, if_valid_d;
    logic            halted_q;
    logic            misaligned_q, misaligned_d;
    logic            flush_raw;
    logic            redirect;
    logic            stall_hold;
    logic            kill_valid;
    logic [PC_W-1:0] target;

    // Upper target bits are outside the fetch address space.
    logic unused_brpc;
    assign unused_brpc = ^BrPC[31:PC_W];

    assign target = {BrPC[PC_W-1:2], 2'b00};

    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        misaligned_d = misaligned_q;
        flush_raw    = 1'b0;
        redirect     = 1'b0;
        stall_hold   = 1'b0;
        kill_valid   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (PcSel && Halt) begin
                    pc_d      = target;
                    flush_raw = 1'b1;
                    redirect  = 1'b1;
                    state_d   = ST_HALTED;
                end else if (Halt) begin
                    flush_raw = 1'b1;
                    state_d   = ST_HALTED;
                end else if (PcSel) begin
                    pc_d       = target;
                    flush_raw  = 1'b1;
                    redirect   = 1'b1;
                    kill_valid = 1'b1;
                    cnt_d      = BUBBLE_LOAD;
                    // A single bubble is covered by kill_valid alone; stay in RUN.
                    state_d    = (BUBBLES <= 1) ? ST_RUN : ST_BUBBLE;
                end else if (Stall) begin
                    stall_hold = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(4);
                end
                if (redirect && (BrPC[1:0] != 2'b00)) begin
                    misaligned_d = 1'b1;
                end
            end
            ST_BUBBLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if_valid_d = (state_d == ST_RUN) && !kill_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            state_q      <= ST_RUN;
            cnt_q        <= 4'd0;
            if_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            if_valid_q   <= if_valid_d;
            halted_q     <= (state_d == ST_HALTED);
            misaligned_q <= misaligned_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] redirect_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt_q <= 16'd0;
            stall_cnt_q    <= 16'd0;
        end else begin
            if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end
            if (stall_hold && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign RedirectCount = redirect_cnt_q;
    assign StallCount    = stall_cnt_q;
`else
    logic unused_stall_hold;
    assign unused_stall_hold = stall_hold;
`endif

    assign PC         = pc_q;
    assign IfValid    = if_valid_q;
    assign Flush      = flush_raw && !reset;
    assign Halted     = halted_q;
    assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit: one instance with BUBBLES=1, one with BUBBLES=3.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PcSel;
    logic [31:0] BrPC;
    logic        Halt;
    logic        Stall;

    logic [8:0]  pc_a, pc_b;
    logic        ifv_a, ifv_b, fl_a, fl_b, hlt_a, hlt_b, mis_a, mis_b;
`ifdef FETCH_STATS_EN
    logic [15:0] rc_a, sc_a, rc_b, sc_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.PC_W(9), .RESET_PC(9'h000), .BUBBLES(1)) dut_a (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt), .Stall(Stall),
        .PC(pc_a), .IfValid(ifv_a), .Flush(fl_a), .Halted(hlt_a), .Misaligned(mis_a)
`ifdef FETCH_STATS_EN
        , .RedirectCount(rc_a), .StallCount(sc_a)
`endif
    );

    fetch_pc_unit #(.PC_W(9), .RESET_PC(9'h000), .BUBBLES(3)) dut_b (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt), .Stall(Stall),
        .PC(pc_b), .IfValid(ifv_b), .Flush(fl_b), .Halted(hlt_b), .Misaligned(mis_b)
`ifdef FETCH_STATS_EN
        , .RedirectCount(rc_b), .StallCount(sc_b)
`endif
    );

    // Inputs for this cycle and the outputs expected while they are applied (before the edge).
    typedef struct {
        logic        rst, pcsel, halt, stall;
        logic [31:0] brpc;
        logic [8:0]  pc;
        logic        ifv, fl, hlt, mis;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    function automatic vec_t mk(input logic r, input logic p, input logic h, input logic s,
                                input logic [31:0] b, input logic [8:0] pc, input logic iv,
                                input logic f, input logic hl, input logic m);
        vec_t v;
        v.rst = r; v.pcsel = p; v.halt = h; v.stall = s; v.brpc = b;
        v.pc = pc; v.ifv = iv; v.fl = f; v.hlt = hl; v.mis = m;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit use_b, input int idx);
        reset = v.rst; PcSel = v.pcsel; Halt = v.halt; Stall = v.stall; BrPC = v.brpc;
        #1;
        if (!use_b) begin
            chk("A.pc",      idx, 32'(pc_a),  32'(v.pc));
            chk("A.ifvalid", idx, 32'(ifv_a), 32'(v.ifv));
            chk("A.flush",   idx, 32'(fl_a),  32'(v.fl));
            chk("A.halted",  idx, 32'(hlt_a), 32'(v.hlt));
            chk("A.misalgn", idx, 32'(mis_a), 32'(v.mis));
        end else begin
            chk("B.pc",      idx, 32'(pc_b),  32'(v.pc));
            chk("B.ifvalid", idx, 32'(ifv_b), 32'(v.ifv));
            chk("B.flush",   idx, 32'(fl_b),  32'(v.fl));
            chk("B.halted",  idx, 32'(hlt_b), 32'(v.hlt));
            chk("B.misalgn", idx, 32'(mis_b), 32'(v.mis));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                    rst p h s brpc          pc     iv fl hl mis
        vecs_a.push_back(mk(1, 1, 0, 0, 32'h40,       9'h000, 0, 0, 0, 0)); // flush gated by reset
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h000, 0, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h004, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h008, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h00C, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 1, 0, 0, 32'h104,      9'h010, 1, 1, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h104, 0, 0, 0, 0));
        vecs_a.push_back(mk(0, 1, 0, 1, 32'h40,       9'h108, 1, 1, 0, 0)); // redirect beats stall
        vecs_a.push_back(mk(0, 0, 0, 1, 32'h0,        9'h040, 0, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 1, 32'h0,        9'h040, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 1, 32'h0,        9'h040, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h040, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 1, 0, 0, 32'h1F8,      9'h044, 1, 1, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h1F8, 0, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h1FC, 1, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h000, 1, 0, 0, 0)); // wrapped
        vecs_a.push_back(mk(0, 1, 0, 0, 32'h106,      9'h004, 1, 1, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h104, 0, 0, 0, 1));
        vecs_a.push_back(mk(0, 1, 0, 0, 32'hFFFF_FE20, 9'h108, 1, 1, 0, 1));
        vecs_a.push_back(mk(0, 1, 1, 0, 32'h80,       9'h020, 0, 1, 0, 1));
        vecs_a.push_back(mk(0, 1, 0, 0, 32'h20,       9'h080, 0, 0, 1, 1)); // halted: ignored
        vecs_a.push_back(mk(0, 0, 1, 1, 32'h0,        9'h080, 0, 0, 1, 1));
        vecs_a.push_back(mk(1, 1, 0, 0, 32'h20,       9'h080, 0, 0, 1, 1));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h000, 0, 0, 0, 0));
        vecs_a.push_back(mk(0, 0, 1, 0, 32'h0,        9'h004, 1, 1, 0, 0)); // halt alone
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h004, 0, 0, 1, 0));
        vecs_a.push_back(mk(1, 0, 0, 0, 32'h0,        9'h004, 0, 0, 1, 0));
        vecs_a.push_back(mk(0, 0, 0, 0, 32'h0,        9'h000, 0, 0, 0, 0));

        // BUBBLES=3: three invalid cycles, inputs ignored during the bubble, reset mid-bubble.
        vecs_b.push_back(mk(0, 0, 0, 0, 32'h0,        9'h000, 0, 0, 0, 0));
        vecs_b.push_back(mk(0, 1, 0, 0, 32'h106,      9'h004, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 1, 1, 1, 32'h20,       9'h104, 0, 0, 0, 1));
        vecs_b.push_back(mk(0, 1, 1, 1, 32'h20,       9'h104, 0, 0, 0, 1));
        vecs_b.push_back(mk(0, 1, 1, 1, 32'h20,       9'h104, 0, 0, 0, 1));
        vecs_b.push_back(mk(0, 0, 0, 0, 32'h0,        9'h104, 1, 0, 0, 1));
        vecs_b.push_back(mk(0, 0, 0, 0, 32'h0,        9'h108, 1, 0, 0, 1));
        vecs_b.push_back(mk(0, 1, 0, 0, 32'h60,       9'h10C, 1, 1, 0, 1));
        vecs_b.push_back(mk(0, 0, 0, 0, 32'h0,        9'h060, 0, 0, 0, 1));
        vecs_b.push_back(mk(1, 0, 0, 0, 32'h0,        9'h060, 0, 0, 0, 1));
        vecs_b.push_back(mk(0, 0, 0, 0, 32'h0,        9'h000, 0, 0, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 0, 32'h0,        9'h004, 1, 0, 0, 0));
        vecs_b.push_back(mk(0, 0, 1, 0, 32'h0,        9'h008, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 1, 0, 0, 32'h40,       9'h008, 0, 0, 1, 0));

        reset = 1'b1; PcSel = 1'b0; Halt = 1'b0; Stall = 1'b0; BrPC = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs_a[i]) apply(vecs_a[i], 1'b0, i);

        // Bring DUT B to a known state before its sequence.
        reset = 1'b1; PcSel = 1'b0; Halt = 1'b0; Stall = 1'b0;
        @(posedge clk);
        #1;
        foreach (vecs_b[i]) apply(vecs_b[i], 1'b1, i);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
